// File: rtl/nvram_upload.sv
// rtl/nvram_upload.sv - HPS ioctl upload responder serving bytes from on-chip RAM
module nvram_upload #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         ADDR_W       = 10,
  parameter int         RAM_SIZE     = 1024,
  parameter int         RAM_LATENCY  = 1,
  parameter logic [7:0] FILL         = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  output logic              active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE,
    S_READY,
    S_FETCH,
    S_RELEASE
  } state_t;

  state_t     state;
  logic       upl_d;
  logic [1:0] cnt;
  logic       start;
  logic       in_range;

  // Only a fresh rising edge of ioctl_upload aimed at our index starts a session.
  assign start    = ioctl_upload & ~upl_d & (ioctl_index == UPLOAD_INDEX);
  // Full-width compare so high address bits cannot alias into the RAM window.
  assign in_range = (ioctl_addr < 25'(RAM_SIZE));

  // Upload edge detector; resets high so an upload left asserted is not re-entered.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      upl_d <= 1'b1;
    end else begin
      upl_d <= ioctl_upload;
    end
  end

  // Session FSM: pause CPU, serve reads through the RAM port, release on upload end.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      active     <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_PAUSE;
            pause_req  <= 1'b1;
            ioctl_wait <= 1'b1;
            active     <= 1'b1;
          end
        end

        S_RELEASE: begin
          // Exactly one cycle here; a start seen now is intentionally dropped.
          state  <= S_IDLE;
          active <= 1'b0;
        end

        default: begin
          if (!ioctl_upload) begin
            // Upload ended: abandon any fetch without touching ioctl_din.
            state      <= S_RELEASE;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            cnt        <= 2'd0;
          end else begin
            case (state)
              S_PAUSE: begin
                ioctl_wait <= 1'b1;
                if (pause_ack) begin
                  state      <= S_READY;
                  ioctl_wait <= 1'b0;
                end
              end

              S_READY: begin
                if (!pause_ack) begin
                  // CPU resumed and owns the RAM again; stall the HPS until re-paused.
                  state      <= S_PAUSE;
                  ioctl_wait <= 1'b1;
                end else if (ioctl_rd) begin
                  if (in_range) begin
                    ram_addr   <= ioctl_addr[ADDR_W-1:0];
                    ram_rd     <= 1'b1;
                    ioctl_wait <= 1'b1;
                    cnt        <= 2'(RAM_LATENCY);
                    state      <= S_FETCH;
                  end else begin
                    ioctl_din <= FILL;
                  end
                end
              end

              S_FETCH: begin
                // The strobe is sampled by the RAM one edge after issue, so data
                // is captured once the counter has run down past its last step.
                if (cnt == 2'd0) begin
                  ioctl_din <= ram_dout;
                  if (pause_ack) begin
                    state      <= S_READY;
                    ioctl_wait <= 1'b0;
                  end else begin
                    state <= S_PAUSE;
                  end
                end else begin
                  cnt <= cnt - 2'd1;
                end
              end

              default: begin
                state <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
